// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready PISO transmitter with one-word holding buffer,
// MSB-first serial output and optional inter-word idle gap.
`default_nettype none

module piso_serializer #(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             so,
   output logic             so_valid,
   output logic             word_start,
   output logic             word_done,
   output logic             busy
);

   localparam int            BW       = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
   localparam logic [3:0]    GAP_INIT = 4'(GAP);
   localparam bit            NO_GAP   = (GAP == 0);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;
   logic [WIDTH-1:0] r_shreg;
   logic [BW-1:0]    r_bitcnt;
   logic [3:0]       r_gapcnt;

   logic w_in_shift;
   logic w_last;
   logic w_accept;
   logic w_xfer;

   assign w_in_shift = (r_state == S_SHIFT);
   assign w_last     = w_in_shift && (r_bitcnt == LAST_BIT);
   assign w_accept   = din_valid && din_ready;

   // Accept needs an empty buffer and transfer needs a full one, so they never collide.
   assign w_xfer = r_hold_full &&
                   ((r_state == S_IDLE) ||
                    (w_last && NO_GAP) ||
                    ((r_state == S_GAP) && (r_gapcnt == 4'd1)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_shreg     <= '0;
         r_bitcnt    <= '0;
         r_gapcnt    <= '0;
      end else begin
         if (w_accept) begin
            r_hold      <= din;
            r_hold_full <= 1'b1;
         end else if (w_xfer) begin
            r_hold_full <= 1'b0;
         end

         if (r_state == S_GAP) begin
            r_gapcnt <= r_gapcnt - 4'd1;
         end

         if (w_xfer) begin
            r_shreg  <= r_hold;
            r_bitcnt <= '0;
            r_state  <= S_SHIFT;
         end else begin
            case (r_state)
               S_IDLE: begin
               end
               S_SHIFT: begin
                  r_shreg <= r_shreg << 1;
                  if (w_last) begin
                     r_bitcnt <= '0;
                     if (NO_GAP) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_state  <= S_GAP;
                        r_gapcnt <= GAP_INIT;
                     end
                  end else begin
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
               S_GAP: begin
                  if (r_gapcnt == 4'd1) begin
                     r_state <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign din_ready  = rst && !r_hold_full;
   assign so         = w_in_shift && r_shreg[WIDTH-1];
   assign so_valid   = w_in_shift;
   assign word_start = w_in_shift && (r_bitcnt == '0);
   assign word_done  = w_last;
   assign busy       = (r_state != S_IDLE) || r_hold_full;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (W4/G0, W4/G2, W8/G0).
`default_nettype none

module tb_piso_serializer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0] din0;
   logic       v0, rdy0, so0, sv0, ws0, wd0, bz0;
   logic [3:0] din1;
   logic       v1, rdy1, so1, sv1, ws1, wd1, bz1;
   logic [7:0] din2;
   logic       v2, rdy2, so2, sv2, ws2, wd2, bz2;

   piso_serializer #(.WIDTH(4), .GAP(0)) u0 (
      .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
      .so(so0), .so_valid(sv0), .word_start(ws0), .word_done(wd0), .busy(bz0));
   piso_serializer #(.WIDTH(4), .GAP(2)) u1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(rdy1),
      .so(so1), .so_valid(sv1), .word_start(ws1), .word_done(wd1), .busy(bz1));
   piso_serializer #(.WIDTH(8), .GAP(0)) u2 (
      .clk(clk), .rst(rst), .din(din2), .din_valid(v2), .din_ready(rdy2),
      .so(so2), .so_valid(sv2), .word_start(ws2), .word_done(wd2), .busy(bz2));

   // Downstream left-shift registers fed by each serial line.
   logic [3:0] q0 = '0;
   logic [3:0] q1 = '0;
   logic [7:0] q2 = '0;
   always @(posedge clk) begin
      if (sv0) q0 <= {q0[2:0], so0};
      if (sv1) q1 <= {q1[2:0], so1};
      if (sv2) q2 <= {q2[6:0], so2};
   end

   logic [3:0] w0 [8];
   logic [3:0] w1 [4];
   logic [7:0] w2 [2];
   int n0 = 0, p0 = 0, n1 = 0, p1 = 0, n2 = 0, p2 = 0;
   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic feed();
      v0   = (p0 < n0);
      din0 = (p0 < n0) ? w0[p0] : 4'h0;
      v1   = (p1 < n1);
      din1 = (p1 < n1) ? w1[p1] : 4'h0;
      v2   = (p2 < n2);
      din2 = (p2 < n2) ? w2[p2] : 8'h00;
   endtask

   task automatic tick();
      logic a0, a1, a2;
      a0 = v0 && rdy0;
      a1 = v1 && rdy1;
      a2 = v2 && rdy2;
      @(posedge clk);
      #1;
      if (a0) p0++;
      if (a1) p1++;
      if (a2) p2++;
      feed();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0]  e4;
      logic [7:0]  e8;
      logic [14:1] esv, eso;

      rst = 1'b0;
      feed();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready0", rdy0, 0);
      chk("rst_sv0",    sv0,  0);
      chk("rst_so0",    so0,  0);
      chk("rst_busy0",  bz0,  0);
      chk("rst_ws0",    ws0,  0);
      chk("rst_wd0",    wd0,  0);
      chk("rst_ready2", rdy2, 0);
      rst = 1'b1;
      #1;
      chk("rel_ready0", rdy0, 1);
      chk("rel_ready1", rdy1, 1);
      chk("rel_busy0",  bz0,  0);

      // Single word 1011
      w0[0] = 4'b1011; n0 = 1; p0 = 0; feed();
      tick();
      chk("s_hold_ready", rdy0, 0);
      chk("s_hold_busy",  bz0,  1);
      chk("s_hold_sv",    sv0,  0);
      e4 = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("s_sv", sv0, 1);
         chk("s_so", so0, e4[3-i]);
         chk("s_ws", ws0, (i == 0));
         chk("s_wd", wd0, (i == 3));
         if (i == 0) chk("s_ready_after_xfer", rdy0, 1);
      end
      tick();
      chk("s_end_sv", sv0, 0);
      chk("s_q",      q0,  4'b1011);
      chk("s_busy",   bz0, 0);

      // Back-to-back 1011, 0110
      w0[0] = 4'b1011; w0[1] = 4'b0110; n0 = 2; p0 = 0; feed();
      tick();
      chk("b2b_pre_sv", sv0, 0);
      e8 = 8'b1011_0110;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("b2b_sv", sv0, 1);
         chk("b2b_so", so0, e8[7-i]);
         chk("b2b_wd", wd0, ((i % 4) == 3));
         chk("b2b_ws", ws0, ((i % 4) == 0));
      end
      tick();
      chk("b2b_end_sv", sv0, 0);
      chk("b2b_q",      q0,  4'b0110);
      chk("b2b_busy",   bz0, 0);

      // Backpressure, 5 words streamed with din_valid held high
      w0[0] = 4'b1011; w0[1] = 4'b0110; w0[2] = 4'b1100;
      w0[3] = 4'b0011; w0[4] = 4'b1001;
      n0 = 5; p0 = 0; feed();
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (k == 1)       chk("bp_ready", rdy0, 0);
         else if (k >= 18) chk("bp_ready", rdy0, 1);
         else              chk("bp_ready", rdy0, (((k - 2) % 4) == 0));
         if (k >= 2 && k <= 21) begin
            e4 = w0[(k - 2) / 4];
            chk("bp_sv", sv0, 1);
            chk("bp_so", so0, e4[3 - ((k - 2) % 4)]);
         end else begin
            chk("bp_sv_idle", sv0, 0);
         end
         if (k >= 6 && ((k - 2) % 4) == 0) chk("bp_q", q0, w0[(k - 6) / 4]);
      end
      chk("bp_busy", bz0, 0);

      // Gap insertion, GAP=2, words 1111 and 0001
      w1[0] = 4'b1111; w1[1] = 4'b0001; n1 = 2; p1 = 0; feed();
      esv = 14'b00011110011110;
      eso = 14'b00010000011110;
      for (int k = 1; k <= 14; k++) begin
         tick();
         chk("gap_sv", sv1, esv[k]);
         chk("gap_so", so1, eso[k]);
         if (k == 6)  chk("gap_q_a", q1, 4'b1111);
         if (k == 12) chk("gap_q_b", q1, 4'b0001);
         if (k == 13) chk("gap_busy_in_gap", bz1, 1);
         if (k == 8)  chk("gap_ws_b", ws1, 1);
      end
      chk("gap_busy_end", bz1, 0);

      // Reset mid-word with the next word already held
      w0[0] = 4'b1010; w0[1] = 4'b0101; n0 = 2; p0 = 0; feed();
      tick();
      tick();
      chk("mr_bit0", so0, 1);
      tick();
      chk("mr_bit1_sv",  sv0,  1);
      chk("mr_bit1_so",  so0,  0);
      chk("mr_held",     rdy0, 0);
      rst = 1'b0;
      #1;
      chk("mr_so",    so0,  0);
      chk("mr_sv",    sv0,  0);
      chk("mr_ws",    ws0,  0);
      chk("mr_wd",    wd0,  0);
      chk("mr_busy",  bz0,  0);
      chk("mr_ready", rdy0, 0);
      tick();
      chk("mr_ready_low", rdy0, 0);
      rst = 1'b1;
      #1;
      chk("mr_rel_ready", rdy0, 1);
      chk("mr_rel_busy",  bz0,  0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mr_quiet_sv", sv0, 0);
      end
      w0[0] = 4'b1100; n0 = 1; p0 = 0; feed();
      tick();
      e4 = 4'b1100;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_new_sv", sv0, 1);
         chk("mr_new_so", so0, e4[3-i]);
      end
      tick();
      chk("mr_new_q", q0, 4'b1100);

      // WIDTH=8, 0xA5
      w2[0] = 8'hA5; n2 = 1; p2 = 0; feed();
      tick();
      chk("w8_pre_sv", sv2, 0);
      e8 = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("w8_sv", sv2, 1);
         chk("w8_so", so2, e8[7-i]);
         chk("w8_ws", ws2, (i == 0));
         chk("w8_wd", wd2, (i == 7));
      end
      tick();
      chk("w8_q",    q2,  8'hA5);
      chk("w8_sv_e", sv2, 0);
      chk("w8_busy", bz2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that feeds the 4-bit left-shift register stage. It accepts WIDTH-bit words over a valid/ready handshake, buffers one word behind the one in flight, and shifts each word out MSB-first on a single serial line. Once the last bit of a word has been shifted, the downstream left-shift register holds that word with its MSB in Q[WIDTH-1]. An optional programmable gap inserts idle cycles between words.

## Interface
- WIDTH, 4: word width in bits; legal range 2..16.
- GAP, 0: idle cycles inserted after each word; legal range 0..15.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word.
- din_ready  output  1  holding buffer empty. A transfer occurs on an edge where din_valid && din_ready.
- so  output  1  serial data; drives the downstream SI.
- so_valid  output  1  so carries a data bit this cycle.
- word_start  output  1  high during bit 0 (MSB) of a word.
- word_done  output  1  high during the last bit (LSB) of a word.
- busy  output  1  state != IDLE or holding buffer full.

## Operation
- Storage:
  - hold register (WIDTH) plus hold_full flag.
  - shreg (WIDTH), bitcnt (ceil log2 WIDTH).
  - gapcnt (4 bits).
  - state: IDLE, SHIFT, GAP.
- Handshake:
  - din_ready = rst && !hold_full.
  - On accept, hold <= din and hold_full <= 1.
  - Accept and transfer never coincide, because transfer requires hold_full and accept requires !hold_full.
- Transfer: load shreg from hold, clear hold_full, bitcnt <= 0, state <= SHIFT. Transfer occurs when:
  - state is IDLE and hold_full, or
  - state is SHIFT at the last bit with GAP==0 and hold_full, or
  - state is GAP with gapcnt==1 and hold_full.
- IDLE: if hold_full, transfer; otherwise stay in IDLE.
- SHIFT, each edge: shreg <= shreg << 1, bitcnt <= bitcnt+1. When bitcnt==WIDTH-1:
  - GAP>0: state <= GAP, gapcnt <= GAP.
  - GAP==0 and hold_full: transfer; SHIFT continues with no bubble.
  - GAP==0 and !hold_full: state <= IDLE.
- GAP, each edge: gapcnt <= gapcnt-1. When gapcnt==1:
  - hold_full: transfer.
  - !hold_full: state <= IDLE.
- Outputs, all decoded from registers with no combinational path from din or din_valid:
  - so = shreg[WIDTH-1] in SHIFT, else 0.
  - so_valid = (state==SHIFT).
  - word_start = SHIFT && bitcnt==0.
  - word_done = SHIFT && bitcnt==WIDTH-1.
- Reset, asynchronous at any time including mid-word:
  - state=IDLE, shreg=0, hold=0, hold_full=0, bitcnt=0, gapcnt=0.
  - so=0, so_valid=0, word_start=0, word_done=0, busy=0.
  - din_ready=0 while rst is low, 1 after release.
  - A word partially shifted or held when reset asserts is discarded. No partial word resumes.

## Timing
- Latency from idle: accept on edge N, hold full after N, transfer on N+1, MSB on so during the cycle after N+1.
- A word occupies exactly WIDTH so_valid cycles, followed by GAP idle cycles.
- Sustained throughput: one word per WIDTH+GAP cycles, provided the next word is accepted before the current word's last bit.
- Downstream capture: the consumer shifts SI on every edge where so_valid is high. Its Q equals the transmitted word on the edge that ends the word_done cycle.
- din_ready deasserts the cycle after accept and reasserts the cycle after transfer.

## Test plan
- Single word, WIDTH=4, GAP=0: din=4'b1011 accepted once:
  - 1 cycle after accept, so = 1,0,1,1 over 4 cycles with so_valid high.
  - word_start on cycle 1, word_done on cycle 4.
  - Downstream Q=4'b1011 on the following edge; then IDLE, busy=0.
- Back-to-back, GAP=0: 4'b1011 then 4'b0110 with din_valid held high:
  - 8 contiguous so_valid cycles, so = 1,0,1,1,0,1,1,0.
  - Two word_done pulses, 4 cycles apart.
- Gap insertion, GAP=2, words 4'b1111 and 4'b0001:
  - Exactly 2 cycles with so_valid=0 between the two words.
  - Second word emitted as 0,0,0,1.
- Backpressure: din_valid held high with a new word every accept:
  - din_ready low while hold_full, high the cycle after each transfer.
  - No word lost or duplicated over 5 words.
- Reset mid-word: rst low after 2 bits of 4'b1010 with the next word already held:
  - All outputs 0 immediately, din_ready=0 while rst is low.
  - After release: IDLE, din_ready=1, nothing emitted until a new accept.
- WIDTH=8: din=8'hA5 emits 1,0,1,0,0,1,0,1 MSB-first, with word_done on the 8th bit.
